// File: rtl/raw_mem_check_table.sv
// Table of pending-writer counters, one per tag, for read-after-write hazard checks.
// Several issue lanes search the table, and several allocate/retire ports update it, every cycle.
module raw_mem_check_table #(
  parameter int ENTRY_NUM_BITS = 4,
  parameter int ENTRY_NUM      = 1 << ENTRY_NUM_BITS,
  parameter int CNT_W          = 4,
  parameter int NUM_SRCH       = 4,
  parameter int ADD_PORTS      = 2,
  parameter int SUB_PORTS      = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [NUM_SRCH-1:0]                 srch_vld,
  input  logic [NUM_SRCH*ENTRY_NUM_BITS-1:0]  srch_num,
  output logic [NUM_SRCH-1:0]                 hazard,
  input  logic [ADD_PORTS-1:0]                add_vld,
  input  logic [ADD_PORTS*ENTRY_NUM_BITS-1:0] add_num,
  output logic [ADD_PORTS-1:0]                add_rdy,
  input  logic [SUB_PORTS-1:0]                sub_vld,
  input  logic [SUB_PORTS*ENTRY_NUM_BITS-1:0] sub_num,
  output logic                                any_pending,
  output logic                                err_underflow
);

  localparam int EB        = ENTRY_NUM_BITS;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int RDY_LIMIT = CNT_MAX - ADD_PORTS;

  logic [CNT_W-1:0] cnt     [ENTRY_NUM];
  logic [CNT_W-1:0] cnt_nxt [ENTRY_NUM];
  logic             underflow_nxt;
  logic             pending_nxt;

  always_comb begin
    hazard = '0;
    for (int i = 0; i < NUM_SRCH; i++) begin
      hazard[i] = srch_vld[i] & (cnt[srch_num[i*EB +: EB]] != '0);
    end
  end

  // Headroom for every add port keeps a counter from wrapping even if all ports hit one entry.
  always_comb begin
    add_rdy = '0;
    for (int p = 0; p < ADD_PORTS; p++) begin
      add_rdy[p] = (int'(cnt[add_num[p*EB +: EB]]) <= RDY_LIMIT);
    end
  end

  always_comb begin : update_calc
    logic        [CNT_W+1:0] add_cnt;
    logic        [CNT_W+1:0] sub_cnt;
    logic signed [CNT_W+1:0] sum;
    underflow_nxt = 1'b0;
    pending_nxt   = 1'b0;
    add_cnt       = '0;
    sub_cnt       = '0;
    sum           = '0;
    for (int e = 0; e < ENTRY_NUM; e++) begin
      add_cnt = '0;
      sub_cnt = '0;
      for (int p = 0; p < ADD_PORTS; p++) begin
        if (add_vld[p] && add_rdy[p] && (add_num[p*EB +: EB] == EB'(e))) begin
          add_cnt = add_cnt + (CNT_W+2)'(1);
        end
      end
      for (int q = 0; q < SUB_PORTS; q++) begin
        if (sub_vld[q] && (sub_num[q*EB +: EB] == EB'(e))) begin
          sub_cnt = sub_cnt + (CNT_W+2)'(1);
        end
      end
      sum = $signed({2'b00, cnt[e]} + add_cnt - sub_cnt);
      if (sum < 0) begin
        cnt_nxt[e]    = '0;
        underflow_nxt = 1'b1;
      end else begin
        cnt_nxt[e] = sum[CNT_W-1:0];
      end
      pending_nxt = pending_nxt | (cnt_nxt[e] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int e = 0; e < ENTRY_NUM; e++) begin
        cnt[e] <= '0;
      end
      any_pending   <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      for (int e = 0; e < ENTRY_NUM; e++) begin
        cnt[e] <= cnt_nxt[e];
      end
      any_pending   <= pending_nxt;
      err_underflow <= err_underflow | underflow_nxt;
    end
  end

endmodule

// File: tb/tb_raw_mem_check_table.sv
// Self-checking bench for raw_mem_check_table: directed scenarios followed by random traffic,
// all compared against a per-tag counter model.
module tb_raw_mem_check_table;

  localparam int EB      = 4;
  localparam int EN      = 16;
  localparam int CNT_W   = 4;
  localparam int NS      = 4;
  localparam int AP      = 2;
  localparam int SP      = 2;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [NS-1:0]    srch_vld;
  logic [NS*EB-1:0] srch_num;
  logic [NS-1:0]    hazard;
  logic [AP-1:0]    add_vld;
  logic [AP*EB-1:0] add_num;
  logic [AP-1:0]    add_rdy;
  logic [SP-1:0]    sub_vld;
  logic [SP*EB-1:0] sub_num;
  logic             any_pending;
  logic             err_underflow;

  int model_cnt [EN];
  bit model_err;
  bit model_pending;
  int compared   = 0;
  int mismatched = 0;
  int dropped    = 0;

  raw_mem_check_table #(
    .ENTRY_NUM_BITS(EB),
    .ENTRY_NUM(EN),
    .CNT_W(CNT_W),
    .NUM_SRCH(NS),
    .ADD_PORTS(AP),
    .SUB_PORTS(SP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .srch_vld(srch_vld),
    .srch_num(srch_num),
    .hazard(hazard),
    .add_vld(add_vld),
    .add_num(add_num),
    .add_rdy(add_rdy),
    .sub_vld(sub_vld),
    .sub_num(sub_num),
    .any_pending(any_pending),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Reference: each tag holds a plain integer count of writers still in flight.
  task automatic model_update();
    int a [EN];
    int s [EN];
    int n;
    for (int e = 0; e < EN; e++) begin
      a[e] = 0;
      s[e] = 0;
    end
    if (rst || flush) begin
      for (int e = 0; e < EN; e++) model_cnt[e] = 0;
      model_err     = 1'b0;
      model_pending = 1'b0;
      return;
    end
    for (int p = 0; p < AP; p++) begin
      if (add_vld[p]) begin
        if (model_cnt[add_num[p*EB +: EB]] <= CNT_MAX - AP) a[add_num[p*EB +: EB]]++;
        else dropped++;
      end
    end
    for (int q = 0; q < SP; q++) begin
      if (sub_vld[q]) s[sub_num[q*EB +: EB]]++;
    end
    model_pending = 1'b0;
    for (int e = 0; e < EN; e++) begin
      n = model_cnt[e] + a[e] - s[e];
      if (n < 0) begin
        n = 0;
        model_err = 1'b1;
      end
      model_cnt[e] = n;
      if (n != 0) model_pending = 1'b1;
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [NS-1:0] exp_h;
    logic [AP-1:0] exp_r;
    for (int i = 0; i < NS; i++)
      exp_h[i] = srch_vld[i] && (model_cnt[srch_num[i*EB +: EB]] != 0);
    for (int p = 0; p < AP; p++)
      exp_r[p] = (model_cnt[add_num[p*EB +: EB]] <= CNT_MAX - AP);
    compared++;
    assert (hazard === exp_h) else begin
      mismatched++;
      $error("[TB] FAIL %s hazard: got %b want %b", tag, hazard, exp_h);
    end
    compared++;
    assert (add_rdy === exp_r) else begin
      mismatched++;
      $error("[TB] FAIL %s add_rdy: got %b want %b", tag, add_rdy, exp_r);
    end
    compared++;
    assert (any_pending === model_pending) else begin
      mismatched++;
      $error("[TB] FAIL %s any_pending: got %b want %b", tag, any_pending, model_pending);
    end
    compared++;
    assert (err_underflow === model_err) else begin
      mismatched++;
      $error("[TB] FAIL %s err_underflow: got %b want %b", tag, err_underflow, model_err);
    end
  endtask

  // Drives one cycle of inputs, checks outputs mid-cycle, then steps the model at the edge.
  task automatic applyStimulus(input logic [NS-1:0] sv, input logic [NS*EB-1:0] sn,
                               input logic [AP-1:0] av, input logic [AP*EB-1:0] an,
                               input logic [SP-1:0] bv, input logic [SP*EB-1:0] bn,
                               input logic fl, input string tag);
    srch_vld = sv;
    srch_num = sn;
    add_vld  = av;
    add_num  = an;
    sub_vld  = bv;
    sub_num  = bn;
    flush    = fl;
    #4;
    checkOutput(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    logic [NS*EB-1:0] rsn;
    logic [AP*EB-1:0] ran;
    logic [SP*EB-1:0] rbn;
    rst = 1'b1; flush = 1'b0;
    srch_vld = '0; srch_num = '0; add_vld = '0; add_num = '0; sub_vld = '0; sub_num = '0;
    for (int e = 0; e < EN; e++) model_cnt[e] = 0;
    model_err = 1'b0;
    model_pending = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(4'hF, {4'd15, 4'd2, 4'd1, 4'd0}, 2'b00, '0, 2'b00, '0, 1'b0, "reset_idle");

    // Single writer on tag 5, watched by lane 2.
    applyStimulus(4'b0100, {4'd0, 4'd5, 4'd0, 4'd0}, 2'b01, {4'd0, 4'd5}, 2'b00, '0, 1'b0, "single_t0");
    applyStimulus(4'b0100, {4'd0, 4'd5, 4'd0, 4'd0}, 2'b00, '0, 2'b00, '0, 1'b0, "single_t1");
    applyStimulus(4'b0100, {4'd0, 4'd5, 4'd0, 4'd0}, 2'b00, '0, 2'b00, '0, 1'b0, "single_t2");
    applyStimulus(4'b0100, {4'd0, 4'd5, 4'd0, 4'd0}, 2'b00, '0, 2'b10, {4'd5, 4'd0}, 1'b0, "single_t3");
    applyStimulus(4'b0100, {4'd0, 4'd5, 4'd0, 4'd0}, 2'b00, '0, 2'b00, '0, 1'b0, "single_t4");

    // Dual add with a concurrent minus on tag 7.
    applyStimulus(4'b0001, {12'd0, 4'd7}, 2'b11, {4'd7, 4'd7}, 2'b00, '0, 1'b0, "dual_fill1");
    applyStimulus(4'b0001, {12'd0, 4'd7}, 2'b01, {4'd7, 4'd7}, 2'b00, '0, 1'b0, "dual_fill2");
    applyStimulus(4'b0001, {12'd0, 4'd7}, 2'b11, {4'd7, 4'd7}, 2'b01, {4'd0, 4'd7}, 1'b0, "dual_addsub");
    applyStimulus(4'b0001, {12'd0, 4'd7}, 2'b00, {4'd7, 4'd7}, 2'b11, {4'd7, 4'd7}, 1'b0, "dual_sub1");
    applyStimulus(4'b0001, {12'd0, 4'd7}, 2'b00, {4'd7, 4'd7}, 2'b11, {4'd7, 4'd7}, 1'b0, "dual_sub2");
    applyStimulus(4'b0001, {12'd0, 4'd7}, 2'b00, {4'd7, 4'd7}, 2'b00, '0, 1'b0, "dual_done");

    // Saturation on tag 3: keep adding until add_rdy drops, then drain.
    for (int k = 0; k < 16; k++)
      applyStimulus(4'b1000, {4'd3, 12'd0}, 2'b01, {4'd3, 4'd3}, 2'b00, '0, 1'b0, "sat_fill");
    applyStimulus(4'b1000, {4'd3, 12'd0}, 2'b00, {4'd3, 4'd3}, 2'b00, '0, 1'b0, "sat_hold");
    for (int k = 0; k < 7; k++)
      applyStimulus(4'b1000, {4'd3, 12'd0}, 2'b00, {4'd3, 4'd3}, 2'b11, {4'd3, 4'd3}, 1'b0, "sat_drain");
    applyStimulus(4'b1000, {4'd3, 12'd0}, 2'b00, {4'd3, 4'd3}, 2'b00, '0, 1'b0, "sat_empty");

    // Underflow on tag 9, held until a flush.
    applyStimulus(4'b0010, {8'd0, 4'd9, 4'd0}, 2'b01, {4'd0, 4'd9}, 2'b00, '0, 1'b0, "uf_add");
    applyStimulus(4'b0010, {8'd0, 4'd9, 4'd0}, 2'b00, '0, 2'b11, {4'd9, 4'd9}, 1'b0, "uf_sub");
    for (int k = 0; k < 3; k++)
      applyStimulus(4'b0010, {8'd0, 4'd9, 4'd0}, 2'b00, '0, 2'b00, '0, 1'b0, "uf_hold");

    // Flush mid-operation with entries 0, 4, 8 busy and an add in flight.
    applyStimulus(4'b0111, {4'd0, 4'd8, 4'd4, 4'd0}, 2'b11, {4'd4, 4'd0}, 2'b00, '0, 1'b0, "fl_fill1");
    applyStimulus(4'b0111, {4'd0, 4'd8, 4'd4, 4'd0}, 2'b01, {4'd0, 4'd8}, 2'b00, '0, 1'b0, "fl_fill2");
    applyStimulus(4'b0111, {4'd0, 4'd8, 4'd4, 4'd0}, 2'b01, {4'd0, 4'd4}, 2'b00, '0, 1'b1, "fl_flush");
    applyStimulus(4'hF, {4'd12, 4'd8, 4'd4, 4'd0}, 2'b00, '0, 2'b00, '0, 1'b0, "fl_after");

    // Random traffic concentrated on a few tags to force port collisions.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NS; i++) rsn[i*EB +: EB] = EB'($urandom_range(0, 5));
      for (int p = 0; p < AP; p++) ran[p*EB +: EB] = EB'($urandom_range(0, 5));
      for (int q = 0; q < SP; q++) rbn[q*EB +: EB] = EB'($urandom_range(0, 5));
      applyStimulus(NS'($urandom), rsn, AP'($urandom), ran,
                    ($urandom_range(0, 2) == 0) ? SP'($urandom) : '0, rbn,
                    ($urandom_range(0, 40) == 0), "random");
    end

    $display("[TB] note: %0d add requests issued while not ready were dropped", dropped);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
